// File: rtl/modular_multiplier_pipe_if.sv
// Operand/result streaming bus for modular_multiplier_pipe.
// master: producer of operands and consumer of results (fetch side / bench).
// slave:  the multiplier itself.
interface modular_multiplier_pipe_if #(
  parameter int unsigned WIDTH     = 30,
  parameter int unsigned TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     c;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 range_err;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, c, out_tag, range_err
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, c, out_tag, range_err
  );
endinterface

// File: rtl/modular_multiplier_pipe.sv
// Four-stage pipelined Barrett modular multiplier: c = (a*b) mod MODULUS.
// Global stall: every stage advances only when the output slot is free or
// being drained (adv), so in_ready is simply adv.
// Optional build macro MODMUL_RANGE_CHECK_EN: flags operands >= MODULUS and
// carries the flag alongside the result on range_err (tied 0 otherwise).
module modular_multiplier_pipe #(
  parameter int unsigned     WIDTH     = 30,
  parameter longint unsigned MODULUS   = 64'd998244353,
  parameter int unsigned     TAG_WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst,
  modular_multiplier_pipe_if.slave bus
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned RW      = WIDTH + 2;
  localparam logic [PW:0] POW2    = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0] MU_FULL = POW2 / (PW + 1)'(MODULUS);
  localparam logic [WIDTH:0] MU   = MU_FULL[WIDTH:0];
  localparam logic [RW-1:0] MOD_R  = RW'(MODULUS);
  localparam logic [RW-1:0] MOD2_R = RW'(2 * MODULUS);

  logic adv;

  // Stage 1: full product
  logic                 v1_q;
  logic [PW-1:0]        p1_q, p_d;
  logic [TAG_WIDTH-1:0] tag1_q;
  // Stage 2: Barrett quotient estimate, low product bits kept for S3
  logic                 v2_q;
  logic [WIDTH:0]       q2_q, q_d;
  logic [RW-1:0]        p2_q;
  logic [TAG_WIDTH-1:0] tag2_q;
  // Stage 3: partially reduced remainder, r < 3*MODULUS
  logic                 v3_q;
  logic [RW-1:0]        r3_q, r_d;
  logic [TAG_WIDTH-1:0] tag3_q;
  // Stage 4: output register
  logic                 out_valid_q;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [TAG_WIDTH-1:0] out_tag_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.out_tag   = out_tag_q;

  assign p_d = PW'(bus.a) * PW'(bus.b);
  // t = (p >> (WIDTH-1)) * MU fits in PW+2 bits; only t >> (WIDTH+1) is kept
  assign q_d = (WIDTH + 1)'(((PW + 2)'(p1_q >> (WIDTH - 1)) * (PW + 2)'(MU)) >> (WIDTH + 1));
  // Low RW bits suffice since the true remainder is below 3*MODULUS < 2^RW
  assign r_d = p2_q - RW'(q2_q) * MOD_R;

  // Final correction: at most two subtractions of MODULUS
  always_comb begin
    c_d = WIDTH'(r3_q);
    if (r3_q >= MOD2_R)     c_d = WIDTH'(r3_q - MOD2_R);
    else if (r3_q >= MOD_R) c_d = WIDTH'(r3_q - MOD_R);
  end

  // Stage 1 register: capture product and tag of an accepted pair
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      p1_q   <= '0;
      tag1_q <= '0;
    end else if (adv) begin
      v1_q   <= bus.in_valid;
      p1_q   <= p_d;
      tag1_q <= bus.in_tag;
    end
  end

  // Stage 2 register: quotient estimate
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      q2_q   <= '0;
      p2_q   <= '0;
      tag2_q <= '0;
    end else if (adv) begin
      v2_q   <= v1_q;
      q2_q   <= q_d;
      p2_q   <= p1_q[RW-1:0];
      tag2_q <= tag1_q;
    end
  end

  // Stage 3 register: partial remainder
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      r3_q   <= '0;
      tag3_q <= '0;
    end else if (adv) begin
      v3_q   <= v2_q;
      r3_q   <= r_d;
      tag3_q <= tag2_q;
    end
  end

  // Stage 4 register: fully reduced result, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= v3_q;
      c_q         <= c_d;
      out_tag_q   <= tag3_q;
    end
  end

`ifdef MODMUL_RANGE_CHECK_EN
  localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MODULUS);

  logic err_d, err1_q, err2_q, err3_q, err_q;

  assign err_d         = (bus.a >= MOD_W) || (bus.b >= MOD_W);
  assign bus.range_err = err_q;

  // Range flag rides the pipeline in lockstep with its operands
  always_ff @(posedge clk) begin
    if (rst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      err3_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (adv) begin
      err1_q <= err_d;
      err2_q <= err1_q;
      err3_q <= err2_q;
      err_q  <= err3_q;
    end
  end
`else
  assign bus.range_err = 1'b0;
`endif

endmodule

// File: tb/tb_modular_multiplier_pipe.sv
// Directed bench for modular_multiplier_pipe with an in-order scoreboard.
module tb_modular_multiplier_pipe;

  localparam longint unsigned M = 64'd998244353;
`ifdef MODMUL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [29:0] c;
    logic [7:0]  tag;
    logic        err;
    bit          chk_c;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t exp_q[$];

  modular_multiplier_pipe_if #(.WIDTH(30), .TAG_WIDTH(8)) bus ();

  modular_multiplier_pipe #(
    .WIDTH    (30),
    .MODULUS  (M),
    .TAG_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Present one pair starting at a falling edge; returns at the falling edge
  // after the accepting rising edge. in_valid is left high for back-to-back use.
  task automatic put(input logic [29:0] av, input logic [29:0] bv, input logic [7:0] tv,
                     input logic [29:0] cv, input bit ev, input bit cc);
    int unsigned n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.in_tag   = tv;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("accept_timeout", 64'(n), 64'd0);
    e.c     = cv;
    e.tag   = tv;
    e.err   = RC & ev;
    e.chk_c = cc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: pops on transfer, checks held values while stalled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_tag), 64'hFFFF);
        end else if (bus.out_ready) begin
          e = exp_q.pop_front();
          if (e.chk_c) chk("c", 64'(bus.c), 64'(e.c));
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
          chk("range_err", 64'(bus.range_err), 64'(e.err));
        end else begin
          e = exp_q[0];
          if (e.chk_c) chk("held_c", 64'(bus.c), 64'(e.c));
          chk("held_tag", 64'(bus.out_tag), 64'(e.tag));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_c", 64'(bus.c), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_range_err", 64'(bus.range_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Latency: handshake in cycle 0, result visible in cycle 4
    put(30'd10, 30'd10, 8'h01, 30'd100, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #3;
      chk($sformatf("lat_valid_cyc%0d", k), 64'(bus.out_valid), 64'(k == 4));
      @(negedge clk);
    end
    drain();

    // Back-to-back stream
    put(30'd123456, 30'd7891234, 8'h02, 30'd931940529, 1'b0, 1'b1);
    put(30'd0, 30'd10000, 8'h03, 30'd0, 1'b0, 1'b1);
    put(30'd90, 30'd30, 8'h04, 30'd2700, 1'b0, 1'b1);
    put(30'd40, 30'd23, 8'h05, 30'd920, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // Boundaries
    put(30'd998244352, 30'd998244352, 8'h06, 30'd1, 1'b0, 1'b1);
    put(30'd998244352, 30'd2, 8'h07, 30'd998244351, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for three cycles mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++)
          put(30'(i + 2), 30'(i + 3), 8'(8'h20 + i), 30'((i + 2) * (i + 3)), 1'b0, 1'b1);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          #1;
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Range check flag, followed by an in-range pair
    put(30'd998244353, 30'd5, 8'h55, 30'd0, 1'b1, 1'b0);
    put(30'd3, 30'd4, 8'h56, 30'd12, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // Reset with three results in flight
    put(30'd7, 30'd8, 8'h40, 30'd56, 1'b0, 1'b1);
    put(30'd9, 30'd9, 8'h41, 30'd81, 1'b0, 1'b1);
    put(30'd5, 30'd6, 8'h42, 30'd30, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #3;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    chk("post_rst_idle", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modular_multiplier_pipe.md
Name: modular_multiplier_pipe

Overview:
- Parametrised, fully pipelined modular multiplier computing c = (a*b) mod MODULUS using Barrett reduction.
- Adds valid/ready handshaking, backpressure and a sideband tag, so NTT butterfly units can stream operands with one result per cycle.
- Sits between the twiddle/coefficient fetch path and the butterfly add/sub stage.

Parameters:
- WIDTH, 30, operand/result width in bits.
- MODULUS, 998244353, odd modulus; requires 2^(WIDTH-1) < MODULUS < 2^WIDTH.
- TAG_WIDTH, 8, width of the sideband tag carried alongside each operand pair.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A; 0 <= a < MODULUS.
- b  input  WIDTH  operand B; 0 <= b < MODULUS.
- in_tag  input  TAG_WIDTH  sideband, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- c  output  WIDTH  (a*b) mod MODULUS.
- out_tag  output  TAG_WIDTH  tag of this result.
- range_err  output  1  operand out of range (see Optional Feature).

Behaviour:
- One clock domain; rst is synchronous and active-high. All pipeline valid bits are cleared while rst is high.
- Reset values: out_valid=0, c=0, out_tag=0, range_err=0. in_ready=1 during and after reset.
- Localparam MU = floor(2^(2*WIDTH)/MODULUS), WIDTH+1 bits, computed at elaboration.
- Pipeline, 4 register stages:
  - S1: p = a*b (2*WIDTH bits).
  - S2: t = (p >> (WIDTH-1)) * MU.
  - S3: r = p - (t >> (WIDTH+1))*MODULUS, computed on the low WIDTH+2 bits; r < 3*MODULUS.
  - S4: subtract MODULUS up to twice until r < MODULUS, then register into c.
- Latency: exactly 4 cycles from the in_valid&&in_ready edge to out_valid, when not stalled.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv, combinational.
- When adv=1 every stage shifts by one, including valid bits and tags. When adv=0 all stages hold.
- Bubbles are not compressed.
- A transfer occurs on a cycle with in_valid && in_ready.
- While out_valid && !out_ready, c and out_tag stay stable.
- Throughput: 1 result/cycle when out_ready is held high.
- Ordering is strictly FIFO. Tags are never reordered or dropped.
- Edge case, stalled with a bubble at S1: still stalls. A full global stall is the chosen trade-off for simplicity.
- Reset mid-stream: all in-flight results are discarded. No result appears after rst deasserts unless new input is accepted.
- Operands a=0 or b=0 give c=0. Operands MODULUS-1 with MODULUS-1 give c=1.
- Inputs >= MODULUS without the feature: c is undefined, but the handshake and tag are still correct.

Optional Feature:
- Macro MODMUL_RANGE_CHECK_EN.
- Defined: at S1 the flag (a >= MODULUS) || (b >= MODULUS) is captured. It travels down the pipeline and is presented on range_err with the matching result, under the same hold/stall rules. The result c is still computed from the raw inputs.
- Undefined: no comparators are built and range_err is tied to 0.

Test Plan:
- Reset then a=10, b=10, tag=0x01, out_ready=1 -> c=100, out_tag=0x01, out_valid exactly 4 cycles after acceptance.
- Back-to-back stream: (123456, 7891234), (0, 10000), (90, 30), (40, 23) on consecutive cycles -> c = 931940529, 0, 2700, 920 on 4 consecutive cycles, in order.
- Boundary: a=b=998244352 -> c=1. a=998244352, b=2 -> c=998244351.
- Backpressure: stream 6 pairs with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, c/out_tag held stable, all 6 results delivered in order with no loss or duplication.
- Reset with 3 results in flight -> out_valid=0 the next cycle, and no stale results appear afterwards.
- With MODMUL_RANGE_CHECK_EN: a=998244353, b=5 -> range_err=1 with that result. The next valid pair gives range_err=0. Without the macro, range_err=0 always.
